scm_lut_accumulator: RTL
========================

Name: scm_lut_accumulator

Overview:
- Downstream consumer of the latch-based LUT SCM (C codebooks x K entries, DataTypeWidth each).
- Accepts a stream of C encoding indices, one per codebook in codebook order 0..C-1.
- For each index, issues the SCM read address c*K+k and sums the returned signed LUT values.
- Presents one accumulated result per group of C encodings on a valid/ready output.

Parameters:
C, 32, number of codebooks (encodings per result)
K, 16, prototypes per codebook; must be a power of 2
DataTypeWidth, 16, SCM entry width; signed two's complement
EncWidth, $clog2(K), encoding index width
TotalAddrWidth, $clog2(C*K), SCM read address width; must match the SCM
AccWidth, DataTypeWidth+$clog2(C), accumulator/result width (full growth, no overflow possible)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
enc_valid_i  input  1  encoding valid
enc_ready_o  output  1  encoding accepted when valid && ready
enc_k_i  input  EncWidth  prototype index for current codebook
raddr_o  output  TotalAddrWidth  SCM read address (registered)
rdata_i  input  DataTypeWidth  SCM read data; combinational from raddr_o, same cycle
result_valid_o  output  1  result valid
result_ready_i  input  1  downstream ready
result_o  output  AccWidth  signed sum of C LUT values
busy_o  output  1  high in DRAIN or HOLD, or while a group is partially accepted

Behaviour:
- Reset values, all synchronous on rst_i:
  - all registers cleared: raddr_o=0, result_o=0, result_valid_o=0, busy_o=0.
  - enc_ready_o=1 in the first cycle after reset is released.
  - codebook counter c_q=0, FSM=RUN.
- Reset mid-group or mid-hold discards partial sums and any pending result. No output is produced for that group.
- Address: raddr_o is registered to the concatenation {c_q, enc_k_i} on each accepted beat, i.e. c_q*K+k.
- Pipeline:
  - Stage 1 (accept cycle N): register raddr_o, rd_valid_q=1, rd_first_q=(c_q==0), rd_last_q=(c_q==C-1).
  - Stage 2 (cycle N+1): acc_q <= (rd_first_q ? init : acc_q) + sign_extend(rdata_i). init is 0 unless the optional feature below is compiled in.
  - rd_valid_q=0 in any cycle with no accept; acc_q then holds.
- Codebook counter: c_q increments on every accept and wraps from C-1 to 0.
- FSM:
  - RUN: enc_ready_o=1. Accept on enc_valid_i. Accepting with c_q==C-1 moves to DRAIN. Back-to-back accepts give full throughput of 1 encoding per cycle.
  - DRAIN (1 cycle): enc_ready_o=0. Stage 2 adds the last value; the final sum is written to result_o, result_valid_o<=1, go to HOLD.
  - HOLD: enc_ready_o=0. result_o and result_valid_o are stable until result_ready_i. Handshake completes at valid&&ready: result_valid_o<=0, go to RUN, and enc_ready_o=1 the next cycle.
- Latency: last accept at cycle N gives result_valid_o high at N+2. Minimum C+2 cycles per result with result_ready_i tied high.
- Gaps: enc_valid_i low mid-group is allowed; the partial sum is retained indefinitely.
- enc_k_i is ignored when no accept occurs.
- C==1: every accept is both first and last.

Optional Feature:
SCM_ACC_BIAS_EN
- Defined:
  - adds port bias_i, input, AccWidth, signed.
  - bias_i is sampled on the accept with c_q==0 and used as init, so result = bias + sum.
- Undefined: no bias_i port; init=0.

Test Plan:
- Reset, then C=32 accepts with k=c%16 and SCM entry(c,k)=c+1, result_ready_i=1 -> result_o=528; result_valid_o exactly one cycle, 2 cycles after last accept.
- All 32 entries = -32768 (0x8000) -> result_o = -1048576 (AccWidth=21, 0x100000); no overflow.
- Hold result_ready_i=0 for 10 cycles after valid -> result_o stable, enc_ready_o=0 throughout; one cycle after the handshake, enc_ready_o=1 and a second group (all entries 1) yields 32.
- enc_valid_i toggling 1/0 every cycle for one group -> correct sum; raddr_o = c*16+k on each accept; c_q wraps to 0 after 31.
- rst_i asserted after 10 accepts, then one full group of all-2 entries -> result_o=64, no stale result emitted.
- With SCM_ACC_BIAS_EN, bias_i=-100 on first accept and all entries 5 -> result_o=60.

Source files
------------

// File: rtl/scm_lut_accumulator.sv
// scm_lut_accumulator: sums C signed SCM LUT values addressed by a stream of per-codebook encodings.
// Optional feature macro SCM_ACC_BIAS_EN adds a bias_i port whose value seeds each group's sum.
module scm_lut_accumulator #(
    parameter int unsigned C              = 32,
    parameter int unsigned K              = 16,
    parameter int unsigned DataTypeWidth  = 16,
    parameter int unsigned EncWidth       = $clog2(K),
    parameter int unsigned TotalAddrWidth = $clog2(C * K),
    parameter int unsigned AccWidth       = DataTypeWidth + $clog2(C)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enc_valid_i,
    output logic                      enc_ready_o,
    input  logic [EncWidth-1:0]       enc_k_i,
    output logic [TotalAddrWidth-1:0] raddr_o,
    input  logic [DataTypeWidth-1:0]  rdata_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [AccWidth-1:0]       result_o,
    output logic                      busy_o
`ifdef SCM_ACC_BIAS_EN
    ,
    input  logic signed [AccWidth-1:0] bias_i
`endif
);

    localparam int unsigned CntWidth = (C > 1) ? $clog2(C) : 1;
    localparam logic [CntWidth-1:0] LastC = CntWidth'(C - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]                 state_q;
    logic [CntWidth-1:0]        c_q;
    logic                       rd_valid_q;
    logic                       rd_first_q;
    logic                       rd_last_q;
    logic signed [AccWidth-1:0] acc_q;
    logic signed [AccWidth-1:0] init;
    logic signed [AccWidth-1:0] rd_ext;
    logic signed [AccWidth-1:0] sum;
    logic                       accept;

    assign enc_ready_o = (state_q == ST_RUN);
    assign accept      = enc_valid_i && enc_ready_o;
    assign busy_o      = (state_q != ST_RUN) || (c_q != '0);

    assign rd_ext = AccWidth'($signed(rdata_i));
    assign sum    = (rd_first_q ? init : acc_q) + rd_ext;

`ifdef SCM_ACC_BIAS_EN
    logic signed [AccWidth-1:0] bias_q;

    // Bias is captured on the first beat so it lines up with rd_first_q one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bias_q <= '0;
        end else if (accept && (c_q == '0)) begin
            bias_q <= bias_i;
        end
    end

    assign init = bias_q;
`else
    assign init = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            c_q            <= '0;
            raddr_o        <= '0;
            rd_valid_q     <= 1'b0;
            rd_first_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            acc_q          <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            rd_valid_q <= accept;

            if (accept) begin
                raddr_o    <= TotalAddrWidth'({c_q, enc_k_i});
                rd_first_q <= (c_q == '0);
                rd_last_q  <= (c_q == LastC);
                c_q        <= (c_q == LastC) ? '0 : c_q + 1'b1;
            end

            if (rd_valid_q) begin
                acc_q <= sum;
            end

            case (state_q)
                ST_RUN: begin
                    if (accept && (c_q == LastC)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last beat's read data is on rdata_i now; publish the completed sum.
                    if (rd_valid_q && rd_last_q) begin
                        result_o       <= sum;
                        result_valid_o <= 1'b1;
                        state_q        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        state_q        <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

endmodule
